// File: rtl/masked_rng_z_supply.sv
// rtl/masked_rng_z_supply.sv - eight-lane Galois LFSR randomness supply for a masked datapath
// Lanes are frozen while an operation is in flight and advanced REFRESH_CYCLES times before reuse.
module masked_rng_z_supply #(
  parameter int REFRESH_CYCLES  = 4,
  parameter int STEPS_PER_CYCLE = 8
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        seed_valid,
  input  logic [31:0] seed_data,
  output logic        seed_ready,
  input  logic        reseed,
  input  logic        op_req,
  input  logic        op_done,
  input  logic        flush,
  output logic [31:0] z0,
  output logic [31:0] z1,
  output logic [31:0] z2,
  output logic [31:0] z3,
  output logic [31:0] z4,
  output logic [31:0] z5,
  output logic [31:0] z6,
  output logic [31:0] z7,
  output logic        z_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_UNSEEDED,
    ST_SEEDING,
    ST_READY,
    ST_HOLD,
    ST_REFRESH
  } state_t;

  localparam logic [31:0] POLY         = 32'h0040_0007;
  localparam logic [31:0] ZERO_SUB     = 32'h9E37_79B9;
  localparam logic [3:0]  REFRESH_LAST = 4'(REFRESH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d, k_base;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] lane_q [8];
  logic [31:0] lane_d [8];

  function automatic logic [31:0] advance(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
      if (v[31]) v = {v[30:0], 1'b0} ^ POLY;
      else       v = {v[30:0], 1'b0};
    end
    return v;
  endfunction

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    lane_d     = lane_q;
    k_base     = k_q;
    seed_ready = 1'b0;
    z_valid    = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_UNSEEDED, ST_SEEDING: begin
        seed_ready = 1'b1;
        // A beat arriving with reseed is the first beat of the restarted sequence.
        if (reseed) begin
          k_base  = 3'd0;
          k_d     = 3'd0;
          state_d = ST_SEEDING;
        end
        if (seed_valid) begin
          lane_d[k_base] = (seed_data == 32'd0) ? (ZERO_SUB ^ {29'd0, k_base}) : seed_data;
          k_d            = 3'(k_base + 3'd1);
          state_d        = (k_base == 3'd7) ? ST_READY : ST_SEEDING;
        end
      end
      ST_READY: begin
        z_valid = 1'b1;
        if (reseed) begin
          k_d     = 3'd0;
          state_d = ST_SEEDING;
        end else if (op_req) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (op_done || flush) begin
          if (pend_q || reseed) begin
            k_d     = 3'd0;
            pend_d  = 1'b0;
            state_d = ST_SEEDING;
          end else begin
            cnt_d   = 4'd0;
            state_d = ST_REFRESH;
          end
        end else if (reseed) begin
          pend_d = 1'b1;
        end
      end
      ST_REFRESH: begin
        if (reseed) begin
          k_d     = 3'd0;
          cnt_d   = 4'd0;
          state_d = ST_SEEDING;
        end else begin
          for (int i = 0; i < 8; i++) lane_d[i] = advance(lane_q[i]);
          if (cnt_q == REFRESH_LAST) begin
            cnt_d   = 4'd0;
            state_d = ST_READY;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_UNSEEDED;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= ST_UNSEEDED;
      k_q     <= 3'd0;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      for (int i = 0; i < 8; i++) lane_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      for (int i = 0; i < 8; i++) lane_q[i] <= lane_d[i];
    end
  end

  assign z0 = lane_q[0];
  assign z1 = lane_q[1];
  assign z2 = lane_q[2];
  assign z3 = lane_q[3];
  assign z4 = lane_q[4];
  assign z5 = lane_q[5];
  assign z6 = lane_q[6];
  assign z7 = lane_q[7];

endmodule

// File: tb/tb_masked_rng_z_supply.sv
// tb/tb_masked_rng_z_supply.sv - self-checking bench for masked_rng_z_supply
// Directed vectors plus a randomized operation stream checked against a lane model and scoreboard.
module tb_masked_rng_z_supply;

  localparam int RC = 4;
  localparam int SPC = 8;
  localparam logic [31:0] POLY = 32'h0040_0007;

  typedef logic [7:0][31:0] zvec_t;
  typedef struct {
    logic [31:0] seed;
    logic [31:0] exp_seeded;
    logic [31:0] exp_after_op;
  } vec_t;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        seed_valid = 1'b0;
  logic [31:0] seed_data = 32'd0;
  logic        seed_ready;
  logic        reseed = 1'b0;
  logic        op_req = 1'b0;
  logic        op_done = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] z0, z1, z2, z3, z4, z5, z6, z7;
  logic        z_valid, busy;
  zvec_t       z_now;

  int    n_checks = 0;
  int    n_fail = 0;
  zvec_t mdl = '0;
  zvec_t exp_q [$];
  bit    seen [string];
  logic  prev_busy = 1'b0;
  logic  prev_valid = 1'b0;
  zvec_t prev_z = '0;

  masked_rng_z_supply #(.REFRESH_CYCLES(RC), .STEPS_PER_CYCLE(SPC)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .seed_valid(seed_valid), .seed_data(seed_data),
    .seed_ready(seed_ready), .reseed(reseed), .op_req(op_req), .op_done(op_done),
    .flush(flush), .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6),
    .z7(z7), .z_valid(z_valid), .busy(busy)
  );

  assign z_now = {z7, z6, z5, z4, z3, z2, z1, z0};

  always #5 g_clk = ~g_clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_op(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    for (int n = 0; n < RC * SPC; n++) v = (v << 1) ^ (v[31] ? POLY : 32'd0);
    return v;
  endfunction

  function automatic logic [31:0] m_seed(input logic [31:0] w, input int k);
    return (w == 32'd0) ? (32'h9E37_79B9 ^ 32'(k)) : w;
  endfunction

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset();
    g_reset = 1'b1;
    seed_valid = 1'b0; reseed = 1'b0; op_req = 1'b0; op_done = 1'b0; flush = 1'b0;
    tick();
    g_reset = 1'b0;
    mdl = '0;
    exp_q.delete();
    seen.delete();
  endtask

  task automatic seed_beats(input zvec_t w, input int first, input int n, input int gap_max);
    for (int i = first; i < first + n; i++) begin
      for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
        seed_data = $urandom;
        tick();
      end
      seed_valid = 1'b1;
      seed_data  = w[i];
      mdl[i]     = m_seed(w[i], i);
      if (i == 7) exp_q.push_back(mdl);
      tick();
      seed_valid = 1'b0;
    end
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 64 && !z_valid; c++) tick();
    chk("wait_ready", z_valid, 1'b1);
  endtask

  // Starts in READY; returns after the HOLD exit. Returns 1 if a reseed was raised.
  task automatic do_op(input int hold, input bit use_flush, input int reseed_at, output bit reseeded);
    reseeded = 1'b0;
    op_req = 1'b1;
    tick();
    for (int h = 0; h < hold; h++) begin
      op_req     = $urandom_range(0, 1);
      seed_valid = $urandom_range(0, 1);
      seed_data  = $urandom;
      reseed     = (h == reseed_at);
      if (h == reseed_at) reseeded = 1'b1;
      if (h == hold - 1) begin
        if (use_flush) flush = 1'b1;
        else           op_done = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          op_done = 1'b1;
          flush   = 1'b1;
        end
        if (!reseeded) begin
          for (int i = 0; i < 8; i++) mdl[i] = m_op(mdl[i]);
          exp_q.push_back(mdl);
        end
      end
      tick();
    end
    op_req = 1'b0; op_done = 1'b0; flush = 1'b0; reseed = 1'b0; seed_valid = 1'b0;
  endtask

  always @(negedge g_clk) begin
    if (!g_reset) begin
      chk("busy_and_valid", busy && z_valid, 1'b0);
      if (busy && prev_busy) chk("z_frozen_in_hold", z_now, prev_z);
      if (z_valid && !prev_valid) begin
        string key;
        key = $sformatf("%h", z_now);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_valid", 1'b1, 1'b0);
        end else begin
          chk("sb_z", z_now, exp_q.pop_front());
        end
        chk("z_interval_unique", seen.exists(key), 1'b0);
        seen[key] = 1'b1;
      end
    end
    prev_busy  = busy;
    prev_valid = z_valid;
    prev_z     = z_now;
  end

  initial begin
    vec_t  tbl [8];
    zvec_t w;
    bit    rs;

    tbl[0] = '{32'h0000_0000, 32'h9E37_79B9, 32'h0};
    tbl[1] = '{32'h0000_0001, 32'h0000_0001, 32'h0};
    tbl[2] = '{32'h8000_0000, 32'h8000_0000, 32'h0};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    tbl[4] = '{32'h1234_5678, 32'h1234_5678, 32'h0};
    tbl[5] = '{32'h0000_0000, 32'h9E37_79BC, 32'h0};
    tbl[6] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    tbl[7] = '{32'h0000_0000, 32'h9E37_79BE, 32'h0};
    for (int i = 0; i < 8; i++) tbl[i].exp_after_op = m_op(tbl[i].exp_seeded);
    tbl[1].exp_after_op = 32'h0040_0007;

    // Reset state
    do_reset();
    chk("rst_seed_ready", seed_ready, 1'b1);
    chk("rst_z_valid", z_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_z", z_now, '0);

    // Seeds 1..8 back to back, then one operation
    for (int i = 0; i < 8; i++) w[i] = 32'(i + 1);
    seed_beats(w, 0, 8, 0);
    chk("seed_z_valid", z_valid, 1'b1);
    chk("seed_ready_low", seed_ready, 1'b0);
    chk("seed_z0", z0, 32'd1);
    chk("seed_z7", z7, 32'd8);
    op_req = 1'b1;
    tick();
    op_req = 1'b0;
    for (int h = 0; h < 3; h++) begin
      chk("hold_busy", busy, 1'b1);
      chk("hold_z0", z0, 32'd1);
      if (h == 2) begin
        op_done = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = m_op(mdl[i]);
        exp_q.push_back(mdl);
      end
      tick();
    end
    op_done = 1'b0;
    for (int r = 0; r < RC; r++) begin
      chk("refresh_z_valid", z_valid, 1'b0);
      tick();
    end
    chk("refresh_done_valid", z_valid, 1'b1);
    chk("refresh_z0", z0, 32'h0040_0007);

    // Table vectors: zero substitution and one refresh
    do_reset();
    for (int i = 0; i < 8; i++) w[i] = tbl[i].seed;
    seed_beats(w, 0, 8, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("tbl_seeded_%0d", i), z_now[i], tbl[i].exp_seeded);
    do_op(1, 1'b1, -1, rs);
    wait_ready();
    for (int i = 0; i < 8; i++) chk($sformatf("tbl_after_op_%0d", i), z_now[i], tbl[i].exp_after_op);

    // Reseed during HOLD, then flush
    op_req = 1'b1;
    tick();
    op_req = 1'b0;
    reseed = 1'b1;
    prev_z = z_now;
    tick();
    reseed = 1'b0;
    chk("pend_busy", busy, 1'b1);
    chk("pend_z_frozen", z_now, prev_z);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pend_seed_ready", seed_ready, 1'b1);
    chk("pend_z_valid", z_valid, 1'b0);
    for (int i = 0; i < 8; i++) w[i] = 32'hA500_0000 + 32'(i);
    seed_beats(w, 0, 7, 2);
    chk("pend_7_beats_not_valid", z_valid, 1'b0);
    seed_beats(w, 7, 1, 2);
    chk("pend_8_beats_valid", z_valid, 1'b1);
    chk("pend_new_z3", z3, 32'hA500_0003);

    // Reset after partial seeding, reseed restart in SEEDING
    do_reset();
    for (int i = 0; i < 8; i++) w[i] = 32'h5500_0010 + 32'(i);
    seed_beats(w, 0, 3, 0);
    do_reset();
    chk("mid_rst_seed_ready", seed_ready, 1'b1);
    chk("mid_rst_z_valid", z_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_z", z_now, '0);
    seed_beats(w, 0, 3, 0);
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    for (int i = 0; i < 8; i++) w[i] = 32'h7700_0020 + 32'(i);
    seed_beats(w, 0, 8, 1);
    chk("restart_z0", z0, 32'h7700_0020);
    chk("restart_z_valid", z_valid, 1'b1);

    // Randomized operation stream
    do_reset();
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    seed_beats(w, 0, 8, 1);
    for (int op = 0; op < 10000; op++) begin
      wait_ready();
      if ($urandom_range(0, 99) < 2) begin
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        rs = 1'b1;
      end else begin
        int hold;
        int rat;
        hold = ($urandom_range(0, 3) == 0) ? 2 : 1;
        rat  = ($urandom_range(0, 99) < 2) ? $urandom_range(0, hold - 1) : -1;
        do_op(hold, 1'($urandom_range(0, 1)), rat, rs);
      end
      if (rs) begin
        for (int i = 0; i < 8; i++) w[i] = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
        seed_beats(w, 0, 8, 1);
      end
    end
    wait_ready();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
